uart_tx_fifo: RTL and testbench

//   Buffered UART transmitter: bytes from core logic go into a FIFO and are serialised 8N1
//   (LSB first) on o_Tx_Serial, back-to-back with no idle gap. Upstream can burst up to

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_byte_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and their encoding width.
package uart_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with registered occupancy, full/empty flags and a dropped-write pulse.
module uart_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q, overflow_q;
    logic             do_push, do_pop;

    // A push while full is refused even when a pop frees a slot in the same cycle.
    always_comb begin
        do_push  = push_i && !full_q;
        do_pop   = pop_i && !empty_q;
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_W'(DEPTH));
            empty_q    <= (count_d == '0);
            overflow_q <= push_i && full_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o  = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a back-to-back 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    input  logic                        i_Wr_DV,
    input  logic [7:0]                  i_Wr_Byte,
    output logic                        o_Full,
    output logic                        o_Empty,
    output logic [$clog2(FIFO_DEPTH):0] o_Count,
    output logic                        o_Overflow,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Done
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_serial_q, tx_serial_d;
    logic             tx_active_q, tx_active_d;
    logic             tx_done_q, tx_done_d;
    logic             pop_c;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic             cnt_last;

    uart_byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (i_Clock),
        .rst_ni     (i_Reset_n),
        .push_i     (i_Wr_DV),
        .wr_data_i  (i_Wr_Byte),
        .pop_i      (pop_c),
        .rd_data_o  (fifo_head),
        .full_o     (o_Full),
        .empty_o    (fifo_empty),
        .count_o    (o_Count),
        .overflow_o (o_Overflow)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next state; the last stop-bit clock pops the next byte so frames abut.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_last ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_last) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_last) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_last) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (cnt_last) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so the registered line lines up with the state.
    always_comb begin
        tx_serial_d = 1'b1;
        tx_active_d = (state_d != ST_IDLE);
        tx_done_d   = 1'b0;
        case (state_d)
            ST_START:  tx_serial_d = 1'b0;
            ST_DATA:   tx_serial_d = shift_d[bit_d];
            ST_PARITY: tx_serial_d = ^shift_d;
            ST_STOP:   tx_done_d   = (cnt_d == CNT_LAST);
            default:   tx_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign o_Empty     = fifo_empty;
    assign o_Tx_Serial = tx_serial_q;
    assign o_Tx_Active = tx_active_q;
    assign o_Tx_Done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: per-cycle reference model, line decoder, vector table.
module tb_uart_tx_fifo;

    localparam int CPB   = 87;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CLKS = NBITS * CPB;

    logic          i_Clock;
    logic          i_Reset_n;
    logic          i_Wr_DV;
    logic [7:0]    i_Wr_Byte;
    logic          o_Full, o_Empty, o_Overflow, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
    logic [CW-1:0] o_Count;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Wr_DV     (i_Wr_DV),
        .i_Wr_Byte   (i_Wr_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Tx_Serial (o_Tx_Serial),
        .o_Tx_Active (o_Tx_Active),
        .o_Tx_Done   (o_Tx_Done)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: queue of buffered bytes plus the span of the frame on the line.
    logic [7:0]  m_q[$];
    logic [7:0]  m_byte = 8'h00;
    int          m_fs = 0;
    int          m_fe = -1;
    logic        m_ovf = 1'b0;
    logic [7:0]  exp_rx[$];
    logic [10:0] mon_q[$];
    int          rst_epoch = 0;
    int          ovf_seen = 0;
    int          peak = 0;
    int          done_cyc[$];

    typedef struct packed {
        logic [7:0]  b;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    function automatic logic exp_line(input int c);
        int slot;
        if (c < m_fs || c > m_fe) return 1'b1;
        slot = (c - m_fs) / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[3'(slot - 1)];
`ifdef UART_TX_PARITY_EN
        if (slot == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    task automatic mdl_reset();
        m_q.delete();
        m_fs  = 0;
        m_fe  = -1;
        m_ovf = 1'b0;
    endtask

    task automatic mdl_cycle(input logic wr, input logic [7:0] b);
        int sz;
        sz    = m_q.size();
        m_ovf = wr && (sz == DEPTH);
        if (sz > 0 && cyc >= m_fe) begin
            m_byte = m_q.pop_front();
            exp_rx.push_back(m_byte);
            m_fs = cyc + 1;
            m_fe = cyc + FRAME_CLKS;
        end
        if (wr && sz < DEPTH) m_q.push_back(b);
    endtask

    // One clock: drive inputs, advance the model, compare all outputs just after the edge.
    task automatic step(input logic wr, input logic [7:0] b);
        logic [5+CW:0] act, exp;
        i_Wr_DV   = wr;
        i_Wr_Byte = b;
        @(posedge i_Clock);
        if (!i_Reset_n) mdl_reset();
        else mdl_cycle(wr, b);
        cyc++;
        #1;
        act = {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Full, o_Empty, o_Count};
        exp = {exp_line(cyc), (cyc >= m_fs && cyc <= m_fe), (cyc == m_fe), m_ovf,
               (m_q.size() == DEPTH), (m_q.size() == 0), CW'(m_q.size())};
        check($sformatf("cycle %0d outputs", cyc), 32'(act), 32'(exp));
        if (o_Overflow) ovf_seen++;
        if (o_Tx_Done) done_cyc.push_back(cyc);
        if (int'(o_Count) > peak) peak = int'(o_Count);
        i_Wr_DV = 1'b0;
    endtask

    task automatic idle_until_quiet(input int budget);
        int n;
        n = 0;
        while ((m_q.size() > 0 || cyc <= m_fe + 2) && n < budget) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("quiet within budget", 32'(n < budget), 32'd1);
    endtask

    task automatic check_rx(input string tag, output int nfr);
        logic [10:0] fr;
        logic [7:0]  b;
        nfr = mon_q.size();
        check($sformatf("%s frame count", tag), 32'(mon_q.size()), 32'(exp_rx.size()));
        while (mon_q.size() > 0 && exp_rx.size() > 0) begin
            fr = mon_q.pop_front();
            b  = exp_rx.pop_front();
            check($sformatf("%s frame %02h", tag, b), 32'(fr), 32'(make_frame(b)));
        end
        mon_q.delete();
        exp_rx.delete();
    endtask

    // Line decoder: finds each start edge and samples every bit at its middle.
    initial begin
        forever begin
            @(negedge i_Clock);
            if (i_Reset_n && o_Tx_Serial === 1'b0) begin
                int          ep;
                logic [10:0] fr;
                ep = rst_epoch;
                fr = '0;
                repeat (CPB / 2) @(negedge i_Clock);
                fr[0] = o_Tx_Serial;
                for (int j = 1; j < NBITS; j++) begin
                    repeat (CPB) @(negedge i_Clock);
                    fr[j] = o_Tx_Serial;
                end
                if (ep == rst_epoch) mon_q.push_back(fr);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int nfr, wcyc, d0, ovf0, n;
`ifdef UART_TX_PARITY_EN
        vecs[0] = '{b: 8'hAB, frame: 11'b1_1_10101011_0};
        vecs[1] = '{b: 8'h07, frame: 11'b1_1_00000111_0};
        vecs[2] = '{b: 8'h03, frame: 11'b1_0_00000011_0};
        vecs[3] = '{b: 8'h00, frame: 11'b1_0_00000000_0};
        vecs[4] = '{b: 8'hFF, frame: 11'b1_0_11111111_0};
        vecs[5] = '{b: 8'h3F, frame: 11'b1_0_00111111_0};
`else
        vecs[0] = '{b: 8'hAB, frame: 11'b0_1_10101011_0};
        vecs[1] = '{b: 8'h07, frame: 11'b0_1_00000111_0};
        vecs[2] = '{b: 8'h03, frame: 11'b0_1_00000011_0};
        vecs[3] = '{b: 8'h00, frame: 11'b0_1_00000000_0};
        vecs[4] = '{b: 8'hFF, frame: 11'b0_1_11111111_0};
        vecs[5] = '{b: 8'h3F, frame: 11'b0_1_00111111_0};
`endif
        i_Reset_n = 1'b0;
        i_Wr_DV   = 1'b0;
        i_Wr_Byte = 8'h00;
        mdl_reset();

        // Reset state
        repeat (3) step(1'b0, 8'h00);
        check("reset outputs", 32'({o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Overflow, o_Full, o_Empty, o_Count}),
              32'({6'b100_001, CW'(0)}));
        i_Reset_n = 1'b1;
        step(1'b0, 8'h00);

        // Single byte 0xAB: latency and start-bit width
        step(1'b1, 8'hAB);
        check("t1 empty at N+1", 32'(o_Empty), 32'd0);
        check("t1 count at N+1", 32'(o_Count), 32'd1);
        check("t1 line idle at N+1", 32'(o_Tx_Serial), 32'd1);
        step(1'b0, 8'h00);
        check("t1 start at N+2", 32'(o_Tx_Serial), 32'd0);
        check("t1 count after pop", 32'(o_Count), 32'd0);
        repeat (CPB - 1) step(1'b0, 8'h00);
        check("t1 start last clock", 32'(o_Tx_Serial), 32'd0);
        step(1'b0, 8'h00);
        check("t1 data bit0", 32'(o_Tx_Serial), 32'd1);
        d0 = done_cyc.size();
        idle_until_quiet(5000);
        check("t1 done pulses", 32'(done_cyc.size() - d0), 32'd1);
        check_rx("t1", nfr);

        // Vector table: one frame each, compared bit for bit and timed
        for (int i = 0; i < 6; i++) begin
            logic [10:0] fr;
            wcyc = cyc;
            d0   = done_cyc.size();
            step(1'b1, vecs[i].b);
            idle_until_quiet(5000);
            check($sformatf("vec%0d frame count", i), 32'(mon_q.size()), 32'd1);
            if (mon_q.size() > 0) begin
                fr = mon_q.pop_front();
                check($sformatf("vec%0d frame", i), 32'(fr), 32'(vecs[i].frame));
            end
            check($sformatf("vec%0d done count", i), 32'(done_cyc.size() - d0), 32'd1);
            if (done_cyc.size() > d0)
                check($sformatf("vec%0d frame length", i), 32'(done_cyc[d0] - wcyc - 1), 32'(FRAME_CLKS));
            mon_q.delete();
            exp_rx.delete();
        end

        // Burst of three behind a frame in flight: no gap between frames
        peak = 0;
        d0   = done_cyc.size();
        step(1'b1, 8'h5A);
        repeat (2) step(1'b0, 8'h00);
        step(1'b1, 8'h3F);
        step(1'b1, 8'h00);
        step(1'b1, 8'hFF);
        idle_until_quiet(8000);
        check("t2 peak count", 32'(peak), 32'd3);
        check("t2 done pulses", 32'(done_cyc.size() - d0), 32'd4);
        for (int i = 1; i < 4; i++)
            if (done_cyc.size() > d0 + i)
                check($sformatf("t2 done spacing %0d", i), 32'(done_cyc[d0 + i] - done_cyc[d0 + i - 1]),
                      32'(FRAME_CLKS));
        check("t2 back to idle", 32'(o_Tx_Active), 32'd0);
        check_rx("t2", nfr);

        // Seventeen writes while busy: one dropped, overflow pulses once
        step(1'b1, 8'h10);
        repeat (2) step(1'b0, 8'h00);
        ovf0 = ovf_seen;
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(8'h80 + i));
            if (i == 15) check("t3 full after 16", 32'(o_Full), 32'd1);
        end
        check("t3 overflow pulse", 32'(o_Overflow), 32'd1);
        step(1'b0, 8'h00);
        check("t3 overflow pulses", 32'(ovf_seen - ovf0), 32'd1);

        // Write on the very clock the FSM pops from a full FIFO
        n = 0;
        while (cyc < m_fe && n < 2000) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("t4 full before pop", 32'(o_Full), 32'd1);
        step(1'b1, 8'hEE);
        check("t4 overflow", 32'(o_Overflow), 32'd1);
        check("t4 count", 32'(o_Count), 32'd15);
        idle_until_quiet(20000);
        check_rx("t3", nfr);
        check("t3 frames sent", 32'(nfr), 32'd17);

        // Reset in the middle of data bit 4
        step(1'b1, 8'hC3);
        n = 0;
        while (cyc < m_fs + 5 * CPB + CPB / 2 && n < 2000) begin
            step(1'b0, 8'h00);
            n++;
        end
        exp_rx.delete();
        rst_epoch++;
        i_Reset_n = 1'b0;
        #1;
        check("t5 line high async", 32'(o_Tx_Serial), 32'd1);
        check("t5 inactive async", 32'(o_Tx_Active), 32'd0);
        check("t5 empty", 32'(o_Empty), 32'd1);
        repeat (2) step(1'b0, 8'h00);
        i_Reset_n = 1'b1;
        repeat (NBITS * CPB + CPB) step(1'b0, 8'h00);
        check("t5 aborted frame not decoded", 32'(mon_q.size()), 32'd0);
        mon_q.delete();
        step(1'b1, 8'h55);
        idle_until_quiet(5000);
        check_rx("t5", nfr);

        // Randomized bursts against the model
        for (int r = 0; r < 5; r++) begin
            int nb;
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < nb; k++) begin
                step(1'b1, 8'($urandom));
                repeat ($urandom_range(0, 3)) step(1'b0, 8'h00);
            end
            repeat ($urandom_range(0, 1500)) step(1'b0, 8'h00);
        end
        idle_until_quiet(20000);
        check_rx("random", nfr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
